uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin scheduler that shares one UART transmitter among `N_REQ` byte producers. Each producer raises a request with its byte. The arbiter picks one winner, latches its byte and even-parity bit, and pulses the transmitter's start input. It then waits for frame completion or a watchdog timeout before serving the next producer. It sits between the producer logic and the serial transmitter on the same system clock as the receive path.

## Interface
- `N_REQ`, 4: number of requesters; 2..8.
- `DATA_W`, 8: payload width per requester.
- `TIMEOUT`, 4096: maximum cycles in WAIT_DONE before abort; ≥ 2.
- `clk`  in  1: system clock, all logic on posedge.
- `rst`  in  1: reset. One clock; reset is asynchronous and active-high.
- `req`  in  N_REQ: per-requester request level.
- `req_data`  in  N_REQ*DATA_W: byte of requester i on bits [i*DATA_W +: DATA_W].
- `tx_busy`  in  1: transmitter is shifting a frame.
- `tx_done`  in  1: one-cycle pulse at end of frame (after stop bit).
- `grant`  out  N_REQ: one-hot, high for exactly the ISSUE cycle; acknowledges that the byte was taken.
- `tx_start`  out  1: one-cycle start pulse to the transmitter.
- `tx_data`  out  DATA_W: latched byte; stable from ISSUE until the next ISSUE.
- `tx_parity`  out  1: ^tx_data (even parity, matching the receiver check).
- `owner`  out  clog2(N_REQ): index of the current or last winner.
- `active`  out  1: high in ISSUE and WAIT_DONE.
- `timeout`  out  1: one-cycle pulse when a frame is aborted by the watchdog.

## Operation
- States: IDLE, ISSUE, WAIT_DONE. All outputs are registered or decoded from state.
- **IDLE:** if `|req` and `!tx_busy`, select the first asserted `req[i]` searching circularly from `rr_ptr`. On that edge:
  - latch `req_data[i]` into `tx_data`, and `^` of it into `tx_parity`;
  - set `owner` = i;
  - go to ISSUE.
- **IDLE, no selection:** otherwise stay. `tx_busy` high blocks arbitration even when requests are pending.
- **ISSUE:** for exactly one cycle, `grant[owner]`=1, `tx_start`=1, `active`=1. Go to WAIT_DONE; clear the watchdog counter.
- **WAIT_DONE:** the watchdog counter (width clog2(TIMEOUT)) increments each cycle.
  - On `tx_done`: `rr_ptr` = (owner+1) mod N_REQ, go to IDLE.
  - Counter reaches TIMEOUT-1 without `tx_done`: `timeout` pulses on the next cycle (registered), `rr_ptr` advances the same way, go to IDLE.
- **Priority:** `tx_done` on the terminal count cycle counts as done; no timeout pulse.
- **Ignored inputs:**
  - `tx_done` seen in IDLE or ISSUE is ignored.
  - `req` changes during ISSUE or WAIT_DONE are ignored.
  - A requester that drops `req` before its grant simply forfeits its turn.
- **Requester rule:** hold `req` and `req_data` until `grant[i]`. If `req` is still high after grant, the requester is queued for another byte.
- **Wrap-around:** `rr_ptr` wraps from N_REQ-1 to 0. For N_REQ not a power of 2, modulo is explicit.

## Timing
- **Reset values:** state=IDLE, `rr_ptr`=0, `grant`=0, `tx_start`=0, `tx_data`=0, `tx_parity`=0, `owner`=0, `active`=0, `timeout`=0, counter=0.
- **Reset mid-frame:** return to reset values immediately. The transmitter is not notified; the next start waits for `tx_busy` low.
- **Latency:** request seen in IDLE at edge k → `grant`/`tx_start` high during cycle k+1.
- **Minimum spacing:** `tx_start` to the next `tx_start` is 3 cycles (ISSUE, WAIT_DONE with immediate `tx_done`, IDLE).
- **Timeout:** `timeout` pulse occurs TIMEOUT+1 cycles after the ISSUE cycle.
- **Pulse widths:** `grant` and `tx_start` are never high for two consecutive cycles.

## Test plan
- **Single requester:** only req[2]=1, data 0xA5, `tx_done` 10 cycles after start.
  - Expect one `grant`=0b0100 coincident with `tx_start`.
  - Expect `tx_data`=0xA5, `tx_parity`=0, `owner`=2; `active` drops on the cycle after `tx_done`.
- **Round-robin fairness:** req=0b1111 held continuously with bytes 0x11/0x22/0x33/0x44.
  - Expect grants in order 0,1,2,3,0, and `tx_data` following 0x11,0x22,0x33,0x44,0x11.
  - Then drop req[1]: order becomes 2,3,0,2.
- **Busy hold-off:** `tx_busy`=1 with req[0]=1 for 20 cycles, then `tx_busy`=0.
  - Expect no `grant`/`tx_start` while busy.
  - Expect `tx_start` in the second cycle after busy falls.
- **Watchdog:** TIMEOUT=16, never assert `tx_done`.
  - Expect `timeout` pulse 17 cycles after `tx_start`, `rr_ptr` advanced, return to IDLE.
  - Rerun with `tx_done` exactly on the terminal count: expect no `timeout`.
- **Reset mid-frame:** assert `rst` asynchronously during WAIT_DONE, with owner=3 and `tx_data`=0x7E.
  - Expect all outputs 0 within the same cycle, without waiting for a clock edge.
  - After release, req=0b1001 grants requester 0 first.
- **Parity and stray done:** latch 0x07.
  - Expect `tx_parity`=1.
  - Pulse `tx_done` while in IDLE: no state change and no pointer change.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter among N_REQ producers
module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*DATA_W-1:0]  req_data,
    input  logic                     tx_busy,
    input  logic                     tx_done,
    output logic [N_REQ-1:0]         grant,
    output logic                     tx_start,
    output logic [DATA_W-1:0]        tx_data,
    output logic                     tx_parity,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     active,
    output logic                     timeout
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [IDX_W:0]   N_EXT    = (IDX_W+1)'(N_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] TERM     = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   next_ptr;
    logic [IDX_W:0]     cand;
    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;
    logic [DATA_W-1:0]  sel_byte;
    logic [CNT_W-1:0]   wd_cnt;
    logic               load;
    logic               finish;
    logic               expire;

    // Circular search starting at rr_ptr; the wrap is an explicit subtract so non-power-of-2 N_REQ works.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = rr_ptr;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (cand >= N_EXT) begin
                cand = cand - N_EXT;
            end
            if (!sel_found && req[cand[IDX_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[IDX_W-1:0];
            end
        end
    end

    assign sel_byte = req_data[int'(sel_idx)*DATA_W +: DATA_W];
    assign next_ptr = (owner == LAST_IDX) ? '0 : owner + IDX_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        finish   = 1'b0;
        expire   = 1'b0;
        grant    = '0;
        tx_start = 1'b0;
        active   = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_found && !tx_busy) begin
                    load    = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                grant[owner] = 1'b1;
                tx_start     = 1'b1;
                active       = 1'b1;
                state_d      = WAIT_DONE;
            end
            WAIT_DONE: begin
                active = 1'b1;
                // A done arriving on the terminal count wins over the watchdog.
                if (tx_done) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end else if (wd_cnt == TERM) begin
                    finish  = 1'b1;
                    expire  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_data   <= '0;
            tx_parity <= 1'b0;
            owner     <= '0;
            rr_ptr    <= '0;
            wd_cnt    <= '0;
            timeout   <= 1'b0;
        end else begin
            timeout <= expire;
            if (load) begin
                tx_data   <= sel_byte;
                tx_parity <= ^sel_byte;
                owner     <= sel_idx;
            end
            if (state_q == ISSUE) begin
                wd_cnt <= '0;
            end else if (state_q == WAIT_DONE) begin
                wd_cnt <= wd_cnt + CNT_W'(1);
            end
            if (finish) begin
                rr_ptr <= next_ptr;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
    localparam int N_REQ   = 4;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 16;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        tx_busy;
    logic        tx_done;
    logic [3:0]  grant;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_parity;
    logic [1:0]  owner;
    logic        active;
    logic        timeout;

    logic model_en, busy_m, done_m, busy_man, done_man;
    int   done_delay, m_cnt;

    exp_t       sb_q[$];
    exp_t       mon_e;
    logic [3:0] mon_g;
    logic [3:0] prev_grant;
    int         n_checks, n_fail;
    bit         mon_en, chk_spacing;
    int         cyc, last_start;

    assign tx_busy = model_en ? busy_m : busy_man;
    assign tx_done = model_en ? done_m : done_man;

    uart_tx_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .tx_busy(tx_busy), .tx_done(tx_done), .grant(grant), .tx_start(tx_start),
        .tx_data(tx_data), .tx_parity(tx_parity), .owner(owner), .active(active),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Transmitter model: busy from start, done pulse done_delay cycles after the start cycle.
    initial begin
        busy_m = 1'b0;
        done_m = 1'b0;
        m_cnt  = 0;
        forever begin
            @(posedge clk); #1;
            done_m = 1'b0;
            if (model_en && tx_start === 1'b1) begin
                busy_m = 1'b1;
                m_cnt  = done_delay;
            end else if (model_en && busy_m) begin
                m_cnt--;
                if (m_cnt <= 0) begin
                    done_m = 1'b1;
                    busy_m = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (grant !== 4'b0) begin
                n_checks++;
                if (prev_grant !== 4'b0) begin
                    n_fail++;
                    $display("FAIL grant_width: grant=%b after %b, required single-cycle pulse", grant, prev_grant);
                end
                if (sb_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_grant: grant=%b owner=%0d, required no grant", grant, owner);
                end else begin
                    mon_e = sb_q.pop_front();
                    mon_g = 4'b0001 << mon_e.idx;
                    n_checks++;
                    if (grant !== mon_g || tx_start !== 1'b1) begin
                        n_fail++;
                        $display("FAIL sb_grant: grant=%b tx_start=%b, required %b/1", grant, tx_start, mon_g);
                    end
                    n_checks++;
                    if (tx_data !== mon_e.data || tx_parity !== ^mon_e.data) begin
                        n_fail++;
                        $display("FAIL sb_data: tx_data=%h parity=%b, required %h/%b", tx_data, tx_parity, mon_e.data, ^mon_e.data);
                    end
                    n_checks++;
                    if (owner !== 2'(mon_e.idx)) begin
                        n_fail++;
                        $display("FAIL sb_owner: owner=%0d, required %0d", owner, mon_e.idx);
                    end
                end
                if (chk_spacing && last_start >= 0) begin
                    n_checks++;
                    if (cyc - last_start != 3) begin
                        n_fail++;
                        $display("FAIL start_spacing: %0d cycles, required 3", cyc - last_start);
                    end
                end
                last_start = cyc;
            end else if (tx_start !== 1'b0) begin
                n_checks++; n_fail++;
                $display("FAIL start_without_grant: tx_start=%b grant=%b, required 0", tx_start, grant);
            end
            prev_grant = grant;
        end
    end

    task automatic wait_start(input int budget, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (tx_start === 1'b1) ok = 1'b1;
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_start: no tx_start within %0d cycles, required one", name, budget);
        end
    endtask

    task automatic wait_empty(input int budget, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk); #1;
            if (sb_q.size() == 0) ok = 1'b1;
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_drain: %0d grants outstanding, required 0", name, sb_q.size());
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (active === 1'b0) ok = 1'b1;
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_idle: active=%b after %0d cycles, required 0", name, active, budget);
        end
    endtask

    task automatic pulse_done();
        @(posedge clk); #1 done_man = 1'b1;
        @(posedge clk); #1 done_man = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({grant, tx_start, active, timeout} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: grant=%b start=%b active=%b timeout=%b, required all 0", grant, tx_start, active, timeout);
        end
        n_checks++;
        if ({tx_data, tx_parity, owner} !== 11'b0) begin
            n_fail++;
            $display("FAIL reset_data: tx_data=%h parity=%b owner=%0d, required 0", tx_data, tx_parity, owner);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (active !== 1'b0 || grant !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_release: active=%b grant=%b, required 0", active, grant);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_round_robin();
        model_en   = 1'b1;
        done_delay = 1;
        req_data   = {8'h44, 8'h33, 8'h22, 8'h11};
        sb_q.push_back('{0, 8'h11});
        sb_q.push_back('{1, 8'h22});
        sb_q.push_back('{2, 8'h33});
        sb_q.push_back('{3, 8'h44});
        sb_q.push_back('{0, 8'h11});
        last_start  = -1;
        chk_spacing = 1'b1;
        req = 4'b1111;
        wait_empty(100, "rr_all");
        req = 4'b1101;
        sb_q.push_back('{2, 8'h33});
        sb_q.push_back('{3, 8'h44});
        sb_q.push_back('{0, 8'h11});
        sb_q.push_back('{2, 8'h33});
        wait_empty(100, "rr_drop1");
        req = 4'b0000;
        chk_spacing = 1'b0;
        wait_idle(20, "rr");
    endtask

    task automatic test_single();
        model_en   = 1'b1;
        done_delay = 10;
        req_data   = 32'h00A5_0000;
        sb_q.push_back('{2, 8'hA5});
        req = 4'b0100;
        wait_start(20, "single");
        req = 4'b0000;
        repeat (10) @(negedge clk);
        n_checks++;
        if (tx_done !== 1'b1 || active !== 1'b1) begin
            n_fail++;
            $display("FAIL single_done_cycle: tx_done=%b active=%b, required 1/1", tx_done, active);
        end
        @(negedge clk);
        n_checks++;
        if (active !== 1'b0) begin
            n_fail++;
            $display("FAIL single_active_drop: active=%b, required 0", active);
        end
        n_checks++;
        if (tx_data !== 8'hA5 || tx_parity !== 1'b0 || owner !== 2'd2) begin
            n_fail++;
            $display("FAIL single_hold: tx_data=%h parity=%b owner=%0d, required a5/0/2", tx_data, tx_parity, owner);
        end
    endtask

    task automatic test_busy_holdoff();
        bit bad;
        model_en = 1'b0;
        busy_man = 1'b1;
        req_data = 32'h0000_005A;
        req      = 4'b0001;
        bad      = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (tx_start !== 1'b0 || active !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL busy_block: tx_start/active seen while busy, required none");
        end
        @(posedge clk); #1 busy_man = 1'b0;
        sb_q.push_back('{0, 8'h5A});
        @(negedge clk);
        n_checks++;
        if (tx_start !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_first_cycle: tx_start=%b, required 0", tx_start);
        end
        @(negedge clk);
        n_checks++;
        if (tx_start !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_second_cycle: tx_start=%b, required 1", tx_start);
        end
        req = 4'b0000;
        pulse_done();
        wait_idle(10, "busy");
    endtask

    task automatic test_watchdog();
        model_en = 1'b0;
        busy_man = 1'b0;
        done_man = 1'b0;
        req_data = 32'hC300_8100;
        sb_q.push_back('{1, 8'h81});
        req = 4'b0010;
        wait_start(20, "wd");
        req = 4'b0000;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            n_checks++;
            if (timeout !== (k == 17)) begin
                n_fail++;
                $display("FAIL wd_pulse: cycle %0d timeout=%b, required %b", k, timeout, k == 17);
            end
            if (k == 16 || k == 17) begin
                n_checks++;
                if (active !== (k == 16)) begin
                    n_fail++;
                    $display("FAIL wd_active: cycle %0d active=%b, required %b", k, active, k == 16);
                end
            end
        end
        sb_q.push_back('{3, 8'hC3});
        req = 4'b1010;
        wait_start(20, "wd_ptr");
        req = 4'b0000;
        for (int k = 1; k <= 18; k++) begin
            @(posedge clk); #1 done_man = (k == 16);
            @(negedge clk);
            n_checks++;
            if (timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL wd_term_done: cycle %0d timeout=%b, required 0", k, timeout);
            end
            if (k == 16 || k == 17) begin
                n_checks++;
                if (active !== (k == 16)) begin
                    n_fail++;
                    $display("FAIL wd_term_active: cycle %0d active=%b, required %b", k, active, k == 16);
                end
            end
        end
        done_man = 1'b0;
    endtask

    task automatic test_parity_stray();
        req_data = 32'h0000_0700;
        sb_q.push_back('{1, 8'h07});
        req = 4'b0010;
        wait_start(20, "par");
        req = 4'b0000;
        n_checks++;
        if (tx_parity !== 1'b1) begin
            n_fail++;
            $display("FAIL parity_07: tx_parity=%b, required 1", tx_parity);
        end
        pulse_done();
        wait_idle(10, "par");
        pulse_done();
        repeat (3) @(negedge clk);
        n_checks++;
        if (active !== 1'b0 || tx_data !== 8'h07 || owner !== 2'd1) begin
            n_fail++;
            $display("FAIL stray_done_state: active=%b tx_data=%h owner=%0d, required 0/07/1", active, tx_data, owner);
        end
        n_checks++;
        if (dut.rr_ptr !== 2'd2) begin
            n_fail++;
            $display("FAIL stray_done_ptr: rr_ptr=%0d, required 2", dut.rr_ptr);
        end
    endtask

    task automatic test_reset_mid_frame();
        req_data = 32'h7E00_003C;
        sb_q.push_back('{3, 8'h7E});
        req = 4'b1000;
        wait_start(20, "rst");
        req = 4'b0000;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({grant, tx_start, active, timeout} !== 7'b0) begin
            n_fail++;
            $display("FAIL async_reset_ctrl: grant=%b start=%b active=%b timeout=%b, required 0", grant, tx_start, active, timeout);
        end
        n_checks++;
        if ({tx_data, tx_parity, owner} !== 11'b0) begin
            n_fail++;
            $display("FAIL async_reset_data: tx_data=%h parity=%b owner=%0d, required 0", tx_data, tx_parity, owner);
        end
        @(posedge clk); #1 rst = 1'b0;
        sb_q.push_back('{0, 8'h3C});
        req = 4'b1001;
        wait_start(20, "rst_after");
        req = 4'b0000;
        pulse_done();
        wait_idle(10, "rst_after");
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish, required completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req = '0; req_data = '0;
        model_en = 1'b0; busy_man = 1'b0; done_man = 1'b0; done_delay = 1;
        n_checks = 0; n_fail = 0; mon_en = 1'b0; chk_spacing = 1'b0;
        cyc = 0; last_start = -1; prev_grant = '0;
        test_reset();
        test_round_robin();
        test_single();
        test_busy_holdoff();
        test_watchdog();
        test_parity_stray();
        test_reset_mid_frame();
        repeat (3) @(negedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: %0d grants never seen, required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
